// File: rtl/cpu_pkg.sv
// Shared constants, FSM state type and access-size encodings for the memory stage.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] MOV_BYTE_LO = 4'h1;
  localparam logic [3:0] MOV_BYTE_HI = 4'h2;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_e;

endpackage

// File: rtl/mem_stage_wb_mwb_reg.sv
// MEM/WB pipeline register: loads a full writeback record or inserts a bubble.
module mwb_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              regWrite_i,
  input  logic [REG_W-1:0]  regRd_i,
  input  logic [DATA_W-1:0] wbData_i,
  input  logic              r15_i,
  input  logic [DATA_W-1:0] remainder_i,
  output logic              regWrite_o,
  output logic [REG_W-1:0]  regRd_o,
  output logic [DATA_W-1:0] wbData_o,
  output logic              r15_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic              regWrite_q;
  logic [REG_W-1:0]  regRd_q;
  logic [DATA_W-1:0] wbData_q;
  logic              r15_q;
  logic [DATA_W-1:0] remainder_q;

  // A bubble only has to kill the two write enables; the payload may go stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_q  <= 1'b0;
      regRd_q     <= '0;
      wbData_q    <= '0;
      r15_q       <= 1'b0;
      remainder_q <= '0;
    end else if (load_i) begin
      regWrite_q  <= regWrite_i;
      regRd_q     <= regRd_i;
      wbData_q    <= wbData_i;
      r15_q       <= r15_i;
      remainder_q <= remainder_i;
    end else begin
      regWrite_q  <= 1'b0;
      r15_q       <= 1'b0;
    end
  end

  assign regWrite_o  = regWrite_q;
  assign regRd_o     = regRd_q;
  assign wbData_o    = wbData_q;
  assign r15_o       = r15_q;
  assign remainder_o = remainder_q;

endmodule

// File: rtl/mem_stage_wb.sv
// Memory-stage controller: runs the req/ack data-memory access and feeds MEM/WB.
// Optional byte-lane access sizing is enabled by defining MEM_STAGE_BYTE_EN.
module mem_stage_wb
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exm_mem_to_reg,
  input  logic              exm_mem_write,
  input  logic              exm_mem_read,
  input  logic              exm_r15,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_alu_result,
  input  logic [DATA_W-1:0] exm_alu_remainder,
  input  logic [DATA_W-1:0] exm_op1,
  input  logic [3:0]        exm_mov_op,
  input  logic [REG_W-1:0]  exm_reg_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_be,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              mwb_reg_write,
  output logic [REG_W-1:0]  mwb_reg_rd,
  output logic [DATA_W-1:0] mwb_wb_data,
  output logic              mwb_r15,
  output logic [DATA_W-1:0] mwb_remainder
);

  mem_state_e        state_q;
  logic              req_q, we_q, regWrite_q, r15_q, loadSel_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rem_q;
  logic [1:0]        be_q;
  logic [REG_W-1:0]  rd_q;

  logic              memOp;
  logic [1:0]        beSel;
  logic [DATA_W-1:0] wdataSel, loadData;

  assign memOp = exm_mem_read | exm_mem_write;

`ifdef MEM_STAGE_BYTE_EN
  always_comb begin
    beSel    = BE_WORD;
    wdataSel = exm_op1;
    case (exm_mov_op)
      MOV_BYTE_LO: begin
        beSel    = BE_LO;
        wdataSel = {2{exm_op1[7:0]}};
      end
      MOV_BYTE_HI: begin
        beSel    = BE_HI;
        wdataSel = {2{exm_op1[7:0]}};
      end
      default: ;
    endcase
  end

  // Byte loads are steered by the lane that was actually requested.
  always_comb begin
    loadData = dmem_rdata;
    case (be_q)
      BE_LO:   loadData = {{(DATA_W-8){1'b0}}, dmem_rdata[7:0]};
      BE_HI:   loadData = {{(DATA_W-8){1'b0}}, dmem_rdata[15:8]};
      default: ;
    endcase
  end
`else
  logic unusedMovOp;
  assign unusedMovOp = ^exm_mov_op;
  assign beSel       = BE_WORD;
  assign wdataSel    = exm_op1;
  assign loadData    = dmem_rdata;
`endif

  // Request and capture registers stay frozen for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 2'b00;
      rd_q       <= '0;
      regWrite_q <= 1'b0;
      r15_q      <= 1'b0;
      rem_q      <= '0;
      loadSel_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memOp) begin
            state_q    <= ACCESS;
            req_q      <= 1'b1;
            we_q       <= exm_mem_write;
            addr_q     <= exm_alu_result;
            wdata_q    <= wdataSel;
            be_q       <= beSel;
            rd_q       <= exm_reg_rd;
            regWrite_q <= exm_reg_write;
            r15_q      <= exm_r15;
            rem_q      <= exm_alu_remainder;
            loadSel_q  <= exm_mem_to_reg & exm_mem_read & ~exm_mem_write;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  assign mem_stall = ((state_q == IDLE) & memOp) | ((state_q == ACCESS) & ~dmem_ack);

  logic              mwbLoad, mwbRegWrite, mwbR15;
  logic [REG_W-1:0]  mwbRd;
  logic [DATA_W-1:0] mwbData, mwbRem;

  always_comb begin
    mwbLoad     = 1'b0;
    mwbRegWrite = exm_reg_write;
    mwbRd       = exm_reg_rd;
    mwbData     = exm_alu_result;
    mwbR15      = exm_r15;
    mwbRem      = exm_alu_remainder;
    if (state_q == IDLE) begin
      mwbLoad = ~memOp;
    end else if (dmem_ack) begin
      mwbLoad     = 1'b1;
      mwbRegWrite = regWrite_q;
      mwbRd       = rd_q;
      mwbData     = loadSel_q ? loadData : addr_q;
      mwbR15      = r15_q;
      mwbRem      = rem_q;
    end
  end

  mwb_reg uMwbReg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (mwbLoad),
    .regWrite_i  (mwbRegWrite),
    .regRd_i     (mwbRd),
    .wbData_i    (mwbData),
    .r15_i       (mwbR15),
    .remainder_i (mwbRem),
    .regWrite_o  (mwb_reg_write),
    .regRd_o     (mwb_reg_rd),
    .wbData_o    (mwb_wb_data),
    .r15_o       (mwb_r15),
    .remainder_o (mwb_remainder)
  );

endmodule
